// File: rtl/result_writer_pkg.sv
// result_writer_pkg: definitions shared by the result writer and its FIFO.
//   ADDR_LMT   - cache-line address width (word address adds 4 offset bits)
//   WADDR_W    - word address width
//   LINE_WORDS - words per cache line
//   state_t    - result writer FSM states
package result_writer_pkg;

  localparam int ADDR_LMT   = 20;
  localparam int WADDR_W    = ADDR_LMT + 4;
  localparam int LINE_WORDS = 16;
  localparam int LINE_OFS_W = $clog2(LINE_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    WAIT_LINE,
    FLUSH,
    WAIT_FLUSH,
    DONE
  } state_t;

endpackage

// File: rtl/result_writer_fifo.sv
// result_fifo: synchronous FIFO with registered pointers and a
// combinational read port (pop_data shows the head entry while !empty).
//   clk, reset         - clock, synchronous active-high reset (empties FIFO)
//   push, push_data    - write one entry; ignored when full
//   pop                - drop the head entry; ignored when empty
//   pop_data           - current head entry
//   full, empty        - occupancy flags
module result_fifo
  import result_writer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  // One extra pointer bit separates the full and empty cases when the
  // index bits are equal.
  logic [PTR_W:0]    wr_ptr_q;
  logic [PTR_W:0]    rd_ptr_q;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign pop_data = mem[rd_ptr_q[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/result_writer.sv
// result_writer: takes a stream of 32-bit results and writes them as words
// at consecutive addresses starting at base_addr. After every completed
// 16-word line and after the closing partial-line flush it waits for the
// write buffer's wr_valid acknowledge.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   start               - pulse in IDLE; latches base_addr and num_words
//   base_addr           - first word address
//   num_words           - words to write (0 completes immediately)
//   res_data/res_valid  - result stream in
//   res_ready           - result stream accept
//   wr_addr/wr_data     - word address/data to the write buffer
//   wr_en               - word write strobe
//   wr_now              - partial-line flush strobe (wr_addr = next address)
//   wr_valid            - write buffer acknowledge, honoured only in waits
//   busy                - from accepted start until done
//   done                - one-cycle completion pulse
//   words_written       - words issued since the last start
//
// Handshake: a result transfers on a rising clk edge where res_valid and
// res_ready are both high. res_ready never depends on res_valid, the source
// may hold res_valid as long as it likes, and res_data must be stable
// whenever res_valid is high.
//
// Output timing: wr_en/wr_addr/wr_data/wr_now/done/words_written are all
// registered and appear the cycle after the decision that produces them.
// The FSM state is visible as state_q for debug and checker binding.
module result_writer
  import result_writer_pkg::*;
#(
  parameter int ADDR_LMT   = result_writer_pkg::ADDR_LMT,
  parameter int FIFO_DEPTH = 16,
  parameter int WAIT_MIN   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_LMT+3:0] base_addr,
  input  logic [31:0]         num_words,
  input  logic [31:0]         res_data,
  input  logic                res_valid,
  output logic                res_ready,
  output logic [ADDR_LMT+3:0] wr_addr,
  output logic [31:0]         wr_data,
  output logic                wr_en,
  output logic                wr_now,
  input  logic                wr_valid,
  output logic                busy,
  output logic                done,
  output logic [31:0]         words_written
);

  localparam int AW     = ADDR_LMT + 4;
  localparam int WCNT_W = (WAIT_MIN > 1) ? $clog2(WAIT_MIN) : 1;
  localparam logic [WCNT_W-1:0]     WAIT_LAST = (WAIT_MIN > 1) ? WCNT_W'(WAIT_MIN - 1) : '0;
  localparam logic [LINE_OFS_W-1:0] LAST_OFS  = LINE_OFS_W'(LINE_WORDS - 1);

  state_t            state_q, state_n;
  logic [AW-1:0]     addr_q, addr_n;
  logic [31:0]       remaining_q, remaining_n;
  logic [31:0]       num_q, num_n;
  logic [31:0]       accept_q, accept_n;
  logic [31:0]       words_q, words_n;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              wr_en_q, wr_en_n;
  logic              wr_now_q, wr_now_n;
  logic [AW-1:0]     wr_addr_q, wr_addr_n;
  logic [31:0]       wr_data_q, wr_data_n;

  logic              push;
  logic              pop;
  logic [31:0]       fifo_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic              wait_met;

  // Acceptance also stops once num_words results have been taken, so
  // surplus results are never absorbed into the FIFO.
  assign res_ready = busy_q && !fifo_full && (accept_q < num_q);
  assign push      = res_valid && res_ready;
  assign wait_met  = (wait_cnt_q >= WAIT_LAST);

  result_fifo #(
    .DATA_W (32),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (res_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_n     = state_q;
    addr_n      = addr_q;
    remaining_n = remaining_q;
    num_n       = num_q;
    accept_n    = accept_q + {31'b0, push};
    words_n     = words_q;
    wait_cnt_n  = '0;
    busy_n      = busy_q;
    done_n      = 1'b0;
    wr_en_n     = 1'b0;
    wr_now_n    = 1'b0;
    wr_addr_n   = wr_addr_q;
    wr_data_n   = wr_data_q;
    pop         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_n   = 1'b1;
          num_n    = num_words;
          accept_n = '0;
          words_n  = '0;
          if (num_words == 32'd0) begin
            state_n = DONE;
          end else begin
            addr_n      = base_addr;
            remaining_n = num_words;
            state_n     = STREAM;
          end
        end
      end

      STREAM: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          wr_en_n     = 1'b1;
          wr_addr_n   = addr_q;
          wr_data_n   = fifo_data;
          addr_n      = addr_q + 1'b1;
          remaining_n = remaining_q - 32'd1;
          words_n     = words_q + 32'd1;
          // A line-closing word never needs a flush, even if it is the last.
          if (addr_q[LINE_OFS_W-1:0] == LAST_OFS) begin
            state_n = WAIT_LINE;
          end else if (remaining_q == 32'd1) begin
            state_n = FLUSH;
          end
        end
      end

      WAIT_LINE: begin
        if (wait_met && wr_valid) begin
          state_n = (remaining_q == 32'd0) ? DONE : STREAM;
        end else begin
          wait_cnt_n = wait_met ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
      end

      FLUSH: begin
        // addr_q already points one past the last word, so its line
        // offset is nonzero here.
        wr_now_n  = 1'b1;
        wr_addr_n = addr_q;
        state_n   = WAIT_FLUSH;
      end

      WAIT_FLUSH: begin
        if (wait_met && wr_valid) begin
          state_n = DONE;
        end else begin
          wait_cnt_n = wait_met ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
      end

      DONE: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      num_q       <= '0;
      accept_q    <= '0;
      words_q     <= '0;
      wait_cnt_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_now_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_n;
      addr_q      <= addr_n;
      remaining_q <= remaining_n;
      num_q       <= num_n;
      accept_q    <= accept_n;
      words_q     <= words_n;
      wait_cnt_q  <= wait_cnt_n;
      busy_q      <= busy_n;
      done_q      <= done_n;
      wr_en_q     <= wr_en_n;
      wr_now_q    <= wr_now_n;
      wr_addr_q   <= wr_addr_n;
      wr_data_q   <= wr_data_n;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign wr_en         = wr_en_q;
  assign wr_now        = wr_now_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign words_written = words_q;

endmodule

// File: tb/tb_result_writer.sv
// tb_result_writer: drives result_writer with randomized result streams and
// acknowledge timing, and checks every write/flush event, the completion
// signals and the reset behaviour against a reference built from the
// address rules (consecutive words, a flush after a partial last line).
module tb_result_writer;

  localparam int ADDR_LMT   = 20;
  localparam int FIFO_DEPTH = 16;
  localparam int WAIT_MIN   = 2;
  localparam int WAW        = ADDR_LMT + 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [WAW-1:0] base_addr;
  logic [31:0]    num_words;
  logic [31:0]    res_data;
  logic           res_valid;
  logic           res_ready;
  logic [WAW-1:0] wr_addr;
  logic [31:0]    wr_data;
  logic           wr_en;
  logic           wr_now;
  logic           wr_valid;
  logic           busy;
  logic           done;
  logic [31:0]    words_written;

  int checks = 0;
  int errors = 0;

  // Observed events (kind 0 = word write, 1 = flush) and reference events.
  int             obs_kind[$];
  logic [WAW-1:0] obs_addr[$];
  logic [31:0]    obs_data[$];
  int             exp_kind[$];
  logic [WAW-1:0] exp_q[$];
  logic [31:0]    exp_data[$];
  logic [31:0]    src_q[$];
  int             gaps[$];

  int          accepted;
  bit          finished;
  logic [31:0] ww_at_done;
  logic        busy_at_done;
  int          stall_seen;

  result_writer #(
    .ADDR_LMT   (ADDR_LMT),
    .FIFO_DEPTH (FIFO_DEPTH),
    .WAIT_MIN   (WAIT_MIN)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .num_words     (num_words),
    .res_data      (res_data),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_en         (wr_en),
    .wr_now        (wr_now),
    .wr_valid      (wr_valid),
    .busy          (busy),
    .done          (done),
    .words_written (words_written)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Word i goes to base+i (mod 2^WAW) carrying the i-th offered result.
  // If the last word does not close a line, one flush follows at last+1.
  function automatic void build_exp(input logic [WAW-1:0] base, input int num);
    logic [WAW-1:0] last;
    exp_kind.delete(); exp_q.delete(); exp_data.delete();
    for (int i = 0; i < num; i++) begin
      exp_kind.push_back(0);
      exp_q.push_back(base + WAW'(i));
      exp_data.push_back(src_q[i]);
    end
    if (num > 0) begin
      last = base + WAW'(num - 1);
      if (last[3:0] != 4'hF) begin
        exp_kind.push_back(1);
        exp_q.push_back(last + 1'b1);
        exp_data.push_back(32'h0);
      end
    end
  endfunction

  // ---------------- driver / monitor ----------------
  // One operation, cycle by cycle: outputs sampled at negedge, inputs
  // driven right after. amode 0 holds wr_valid high throughout; amode 1
  // raises it ack_min..ack_max cycles after each line end or flush.
  // vmode 0: valid always, 1: every other cycle, 2: random.
  task automatic run_op(input logic [WAW-1:0] base, input int num, input int vmode,
                        input int amode, input int ack_min, input int ack_max,
                        input int abort_after, input bit seq_data, input bit stray_start);
    int trig_cyc;
    int ack_wait;
    bit ack_pend;
    int src_idx;
    bit drive_v;
    obs_kind.delete(); obs_addr.delete(); obs_data.delete();
    gaps.delete(); src_q.delete();
    for (int i = 0; i < num + 3; i++) src_q.push_back(seq_data ? 32'(i) : $urandom);
    accepted = 0; finished = 0; stall_seen = 0;
    trig_cyc = -1; ack_wait = 0; ack_pend = 0; src_idx = 0;
    base_addr = base; num_words = 32'(num); start = 1'b1;
    wr_valid = (amode == 0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (stray_start && cyc == 4) begin
        start = 1'b1; base_addr = WAW'($urandom); num_words = $urandom_range(1, 5);
      end
      if ((wr_en || done) && trig_cyc >= 0) begin
        gaps.push_back(cyc - trig_cyc);
        trig_cyc = -1;
      end
      if (wr_en) begin
        obs_kind.push_back(0); obs_addr.push_back(wr_addr); obs_data.push_back(wr_data);
      end
      if (wr_now) begin
        obs_kind.push_back(1); obs_addr.push_back(wr_addr); obs_data.push_back(32'h0);
      end
      if (amode != 0 && (wr_en || done)) wr_valid = 1'b0;
      if ((wr_en && wr_addr[3:0] == 4'hF) || wr_now) begin
        trig_cyc = cyc;
        ack_pend = 1'b1;
        ack_wait = $urandom_range(ack_min, ack_max);
      end
      if (done) begin
        finished = 1'b1; ww_at_done = words_written; busy_at_done = busy;
        res_valid = 1'b0; wr_valid = 1'b0;
        return;
      end
      if (abort_after > 0 && obs_kind.size() >= abort_after) return;
      if (amode != 0 && ack_pend) begin
        if (ack_wait == 0) begin
          wr_valid = 1'b1; ack_pend = 1'b0;
        end else begin
          ack_wait--;
        end
      end
      case (vmode)
        0:       drive_v = 1'b1;
        1:       drive_v = (cyc % 2 == 0);
        default: drive_v = ($urandom_range(0, 2) != 0);
      endcase
      res_valid = drive_v && (src_idx < src_q.size());
      res_data  = (src_idx < src_q.size()) ? src_q[src_idx] : 32'h0;
      if (res_valid && !res_ready && busy && accepted < num) stall_seen++;
      if (res_valid && res_ready) begin
        accepted++; src_idx++;
      end
    end
    res_valid = 1'b0; wr_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({res_ready, wr_en, wr_now, busy, done} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b required 00000", {res_ready, wr_en, wr_now, busy, done});
    end
    checks++;
    if (wr_addr !== '0 || wr_data !== '0 || words_written !== '0) begin
      errors++; $display("FAIL reset_values: got addr=%h data=%h ww=%0d required 0/0/0", wr_addr, wr_data, words_written);
    end
    reset = 1'b0;
    // A res_valid glitch while idle must not be taken.
    for (int i = 0; i < 4; i++) begin
      res_valid = 1'b1; res_data = $urandom;
      @(negedge clk);
      checks++;
      if (res_ready !== 1'b0 || wr_en !== 1'b0) begin
        errors++; $display("FAIL idle_glitch: got res_ready=%b wr_en=%b required 0/0", res_ready, wr_en);
      end
    end
    res_valid = 1'b0;
  endtask

  task automatic test_full_line();
    run_op(24'h40, 16, 0, 1, 3, 3, 0, 1'b1, 1'b0);
    build_exp(24'h40, 16);
    checks++;
    if (!finished) begin errors++; $display("FAIL full_line_done: got no done required done"); end
    checks++;
    if (obs_kind.size() != exp_kind.size()) begin
      errors++; $display("FAIL full_line_count: got %0d events required %0d", obs_kind.size(), exp_kind.size());
    end
    for (int i = 0; i < exp_kind.size() && i < obs_kind.size(); i++) begin
      checks++;
      if (obs_kind[i] != exp_kind[i] || obs_addr[i] !== exp_q[i] || obs_data[i] !== exp_data[i]) begin
        errors++; $display("FAIL full_line_ev%0d: got k=%0d a=%h d=%h required k=%0d a=%h d=%h",
                           i, obs_kind[i], obs_addr[i], obs_data[i], exp_kind[i], exp_q[i], exp_data[i]);
      end
    end
    checks++;
    if (ww_at_done !== 32'd16 || busy_at_done !== 1'b0 || accepted != 16) begin
      errors++; $display("FAIL full_line_end: got ww=%0d busy=%b acc=%0d required 16/0/16", ww_at_done, busy_at_done, accepted);
    end
  endtask

  task automatic test_zero_words();
    bit saw_wr;
    base_addr = 24'h123; num_words = 32'd0; start = 1'b1; res_valid = 1'b1; res_data = 32'hdead;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, done, res_ready} !== 3'b100) begin
      errors++; $display("FAIL zero_c1: got busy/done/ready=%b required 100", {busy, done, res_ready});
    end
    saw_wr = wr_en || wr_now;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b01 || words_written !== 32'd0) begin
      errors++; $display("FAIL zero_c2: got busy/done=%b ww=%0d required 01/0", {busy, done}, words_written);
    end
    saw_wr = saw_wr || wr_en || wr_now;
    @(negedge clk);
    res_valid = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00 || saw_wr || wr_en || wr_now) begin
      errors++; $display("FAIL zero_c3: got busy/done=%b writes_seen=%b required 00/0", {busy, done}, saw_wr || wr_en || wr_now);
    end
  endtask

  task automatic test_partial_flush();
    run_op(24'h100, 5, 2, 1, 0, 4, 0, 1'b0, 1'b0);
    build_exp(24'h100, 5);
    checks++;
    if (!finished || obs_kind.size() != exp_kind.size()) begin
      errors++; $display("FAIL flush_count: got done=%b events=%0d required 1/%0d", finished, obs_kind.size(), exp_kind.size());
    end
    for (int i = 0; i < exp_kind.size() && i < obs_kind.size(); i++) begin
      checks++;
      if (obs_kind[i] != exp_kind[i] || obs_addr[i] !== exp_q[i] || obs_data[i] !== exp_data[i]) begin
        errors++; $display("FAIL flush_ev%0d: got k=%0d a=%h d=%h required k=%0d a=%h d=%h",
                           i, obs_kind[i], obs_addr[i], obs_data[i], exp_kind[i], exp_q[i], exp_data[i]);
      end
    end
    checks++;
    if (ww_at_done !== 32'd5 || accepted != 5) begin
      errors++; $display("FAIL flush_end: got ww=%0d acc=%0d required 5/5", ww_at_done, accepted);
    end
  endtask

  task automatic test_toggle_valid();
    run_op(24'h0E, 20, 1, 1, 0, 5, 0, 1'b0, 1'b0);
    build_exp(24'h0E, 20);
    checks++;
    if (!finished || obs_kind.size() != exp_kind.size()) begin
      errors++; $display("FAIL toggle_count: got done=%b events=%0d required 1/%0d", finished, obs_kind.size(), exp_kind.size());
    end
    for (int i = 0; i < exp_kind.size() && i < obs_kind.size(); i++) begin
      checks++;
      if (obs_kind[i] != exp_kind[i] || obs_addr[i] !== exp_q[i] || obs_data[i] !== exp_data[i]) begin
        errors++; $display("FAIL toggle_ev%0d: got k=%0d a=%h d=%h required k=%0d a=%h d=%h",
                           i, obs_kind[i], obs_addr[i], obs_data[i], exp_kind[i], exp_q[i], exp_data[i]);
      end
    end
    checks++;
    if (ww_at_done !== 32'd20) begin
      errors++; $display("FAIL toggle_ww: got %0d required 20", ww_at_done);
    end
  endtask

  task automatic test_fifo_stall();
    // Long acknowledge delay after a short first line lets the FIFO fill.
    run_op(24'h3F8, 40, 0, 1, 30, 30, 0, 1'b0, 1'b0);
    build_exp(24'h3F8, 40);
    checks++;
    if (stall_seen == 0) begin
      errors++; $display("FAIL stall_ready: got no res_ready=0 while full required at least one");
    end
    checks++;
    if (!finished || obs_kind.size() != exp_kind.size() || accepted != 40) begin
      errors++; $display("FAIL stall_count: got done=%b events=%0d acc=%0d required 1/%0d/40",
                         finished, obs_kind.size(), accepted, exp_kind.size());
    end
    for (int i = 0; i < exp_kind.size() && i < obs_kind.size(); i++) begin
      checks++;
      if (obs_kind[i] != exp_kind[i] || obs_addr[i] !== exp_q[i] || obs_data[i] !== exp_data[i]) begin
        errors++; $display("FAIL stall_ev%0d: got k=%0d a=%h d=%h required k=%0d a=%h d=%h",
                           i, obs_kind[i], obs_addr[i], obs_data[i], exp_kind[i], exp_q[i], exp_data[i]);
      end
    end
  endtask

  // Two operations started on the cycle done is seen, with wr_valid held
  // high: every wait then lasts WAIT_MIN cycles, so the next event (write
  // or done) follows a line end or flush by WAIT_MIN+1 cycles.
  task automatic test_back_to_back();
    logic [WAW-1:0] base;
    int num;
    int trig;
    for (int op = 0; op < 2; op++) begin
      base = WAW'($urandom);
      num  = $urandom_range(17, 40);
      run_op(base, num, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      build_exp(base, num);
      trig = 0;
      for (int i = 0; i < exp_kind.size(); i++) begin
        if (exp_kind[i] == 1 || exp_q[i][3:0] == 4'hF) trig++;
      end
      checks++;
      if (!finished || obs_kind.size() != exp_kind.size() || gaps.size() != trig) begin
        errors++; $display("FAIL b2b_count%0d: got done=%b events=%0d waits=%0d required 1/%0d/%0d",
                           op, finished, obs_kind.size(), gaps.size(), exp_kind.size(), trig);
      end
      for (int i = 0; i < exp_kind.size() && i < obs_kind.size(); i++) begin
        checks++;
        if (obs_kind[i] != exp_kind[i] || obs_addr[i] !== exp_q[i] || obs_data[i] !== exp_data[i]) begin
          errors++; $display("FAIL b2b_ev%0d_%0d: got k=%0d a=%h d=%h required k=%0d a=%h d=%h",
                             op, i, obs_kind[i], obs_addr[i], obs_data[i], exp_kind[i], exp_q[i], exp_data[i]);
        end
      end
      for (int i = 0; i < gaps.size(); i++) begin
        checks++;
        if (gaps[i] != WAIT_MIN + 1) begin
          errors++; $display("FAIL b2b_wait%0d_%0d: got %0d cycles required %0d", op, i, gaps[i], WAIT_MIN + 1);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [WAW-1:0] base;
    base = 24'h200;
    run_op(base, 30, 0, 1, 2, 2, 7, 1'b0, 1'b0);
    build_exp(base, 30);
    checks++;
    if (obs_kind.size() != 7) begin
      errors++; $display("FAIL rmid_prefix: got %0d events required 7", obs_kind.size());
    end
    for (int i = 0; i < 7 && i < obs_kind.size(); i++) begin
      checks++;
      if (obs_addr[i] !== exp_q[i] || obs_data[i] !== exp_data[i]) begin
        errors++; $display("FAIL rmid_ev%0d: got a=%h d=%h required a=%h d=%h", i, obs_addr[i], obs_data[i], exp_q[i], exp_data[i]);
      end
    end
    reset = 1'b1; res_valid = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({res_ready, wr_en, wr_now, busy, done} !== 5'b0 || wr_addr !== '0 || wr_data !== '0 || words_written !== '0) begin
      errors++; $display("FAIL rmid_reset: got flags=%b addr=%h data=%h ww=%0d required 0",
                         {res_ready, wr_en, wr_now, busy, done}, wr_addr, wr_data, words_written);
    end
    reset = 1'b0;
    base = 24'h5A3;
    run_op(base, 9, 2, 1, 0, 3, 0, 1'b0, 1'b0);
    build_exp(base, 9);
    checks++;
    if (!finished || obs_kind.size() != exp_kind.size() || ww_at_done !== 32'd9) begin
      errors++; $display("FAIL rmid_after: got done=%b events=%0d ww=%0d required 1/%0d/9",
                         finished, obs_kind.size(), ww_at_done, exp_kind.size());
    end
    for (int i = 0; i < exp_kind.size() && i < obs_kind.size(); i++) begin
      checks++;
      if (obs_kind[i] != exp_kind[i] || obs_addr[i] !== exp_q[i] || obs_data[i] !== exp_data[i]) begin
        errors++; $display("FAIL rmid_after_ev%0d: got k=%0d a=%h d=%h required k=%0d a=%h d=%h",
                           i, obs_kind[i], obs_addr[i], obs_data[i], exp_kind[i], exp_q[i], exp_data[i]);
      end
    end
  endtask

  // Random bases (first one wraps the address space), lengths, valid and
  // acknowledge patterns, with a stray start pulse mid-operation.
  task automatic test_random();
    logic [WAW-1:0] base;
    int num;
    for (int op = 0; op < 6; op++) begin
      base = (op == 0) ? 24'hFFFFF9 : WAW'($urandom);
      num  = $urandom_range(1, 40);
      run_op(base, num, $urandom_range(0, 2), 1, 0, 5, 0, 1'b0, 1'b1);
      build_exp(base, num);
      checks++;
      if (!finished || obs_kind.size() != exp_kind.size() || ww_at_done !== 32'(num) || accepted != num) begin
        errors++; $display("FAIL rand_end%0d: got done=%b events=%0d ww=%0d acc=%0d required 1/%0d/%0d/%0d",
                           op, finished, obs_kind.size(), ww_at_done, accepted, exp_kind.size(), num, num);
      end
      for (int i = 0; i < exp_kind.size() && i < obs_kind.size(); i++) begin
        checks++;
        if (obs_kind[i] != exp_kind[i] || obs_addr[i] !== exp_q[i] || obs_data[i] !== exp_data[i]) begin
          errors++; $display("FAIL rand_ev%0d_%0d: got k=%0d a=%h d=%h required k=%0d a=%h d=%h",
                             op, i, obs_kind[i], obs_addr[i], obs_data[i], exp_kind[i], exp_q[i], exp_data[i]);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
    res_data = '0; res_valid = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_full_line();
    test_zero_words();
    test_partial_flush();
    test_toggle_valid();
    test_fifo_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
